// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: grid-stepped player motion for the Pacman core.
// Each step attempt waits STEP_DIV cycles, then computes a candidate cell
// and asks the external maze lookup (wall_req/wall_ack) whether it is free.
// Optional feature macro: TURN_BUFFER_EN. When it is defined, a blocked turn
// request falls back to a second query along the current heading, and the
// turn is kept pending so it can be retried on later ticks.
module sprite_motion_ctrl #(
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120,
  parameter int STEP_DIV = 500000,
  parameter int START_X  = 80,
  parameter int START_Y  = 80,
  parameter int WRAP     = 1
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           startGame,
  input  logic [1:0]     direction,
  input  logic           wall_ack,
  input  logic           wall_blocked,
  output logic           wall_req,
  output logic [X_W-1:0] wall_x,
  output logic [Y_W-1:0] wall_y,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     heading,
  output logic           moving,
  output logic           move_tick,
  output logic [15:0]    step_count
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [X_W-1:0]   X_MAX    = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]   X_INIT   = X_W'(START_X);
  localparam logic [Y_W-1:0]   Y_INIT   = Y_W'(START_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_WAIT,
    S_EVAL,
    S_REQ,
    S_MOVE,
    S_BLOCK
`ifdef TURN_BUFFER_EN
    , S_EVAL2
`endif
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       req_dir_q;
  logic             wall_req_q;
  logic [X_W-1:0]   wall_x_q;
  logic [Y_W-1:0]   wall_y_q;
  logic [X_W-1:0]   pos_x_q;
  logic [Y_W-1:0]   pos_y_q;
  logic [1:0]       heading_q;
  logic             moving_q;
  logic             move_tick_q;
  logic [15:0]      step_count_q;
`ifdef TURN_BUFFER_EN
  logic             second_q;
  logic [1:0]       pending_dir_q;
  logic             pending_vld_q;
`endif

  logic [1:0]     eval_dir;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           cand_off;

`ifdef TURN_BUFFER_EN
  assign eval_dir = (state_q == S_EVAL2) ? heading_q : direction;
`else
  assign eval_dir = direction;
`endif

  // Neighbour cell one step along eval_dir, wrapped at the grid edges;
  // cand_off flags that the wrap was needed.
  always_comb begin
    cand_x   = pos_x_q;
    cand_y   = pos_y_q;
    cand_off = 1'b0;
    case (eval_dir)
      2'd0: begin
        if (pos_y_q == '0) begin
          cand_off = 1'b1;
          cand_y   = Y_MAX;
        end else begin
          cand_y = pos_y_q - 1'b1;
        end
      end
      2'd1: begin
        if (pos_x_q == X_MAX) begin
          cand_off = 1'b1;
          cand_x   = '0;
        end else begin
          cand_x = pos_x_q + 1'b1;
        end
      end
      2'd2: begin
        if (pos_y_q == Y_MAX) begin
          cand_off = 1'b1;
          cand_y   = '0;
        end else begin
          cand_y = pos_y_q + 1'b1;
        end
      end
      default: begin
        if (pos_x_q == '0) begin
          cand_off = 1'b1;
          cand_x   = X_MAX;
        end else begin
          cand_x = pos_x_q - 1'b1;
        end
      end
    endcase
  end

  // Motion FSM with registered outputs; dropping startGame re-initialises
  // everything exactly like reset, which also cancels an in-flight query.
  always_ff @(posedge CLOCK_50) begin
    if (reset || !startGame) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      req_dir_q    <= 2'd0;
      wall_req_q   <= 1'b0;
      wall_x_q     <= '0;
      wall_y_q     <= '0;
      pos_x_q      <= X_INIT;
      pos_y_q      <= Y_INIT;
      heading_q    <= 2'd0;
      moving_q     <= 1'b0;
      move_tick_q  <= 1'b0;
      step_count_q <= 16'd0;
`ifdef TURN_BUFFER_EN
      second_q      <= 1'b0;
      pending_dir_q <= 2'd0;
      pending_vld_q <= 1'b0;
`endif
    end else begin
      move_tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          div_q   <= '0;
          state_q <= S_RUN_WAIT;
        end
        S_RUN_WAIT: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            state_q <= S_EVAL;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        S_EVAL: begin
          req_dir_q <= direction;
`ifdef TURN_BUFFER_EN
          second_q <= 1'b0;
          if (pending_vld_q && (pending_dir_q != direction)) begin
            pending_vld_q <= 1'b0;
          end
          if (cand_off && (WRAP == 0)) begin
            state_q <= (direction != heading_q) ? S_EVAL2 : S_BLOCK;
          end else begin
            wall_x_q   <= cand_x;
            wall_y_q   <= cand_y;
            wall_req_q <= 1'b1;
            state_q    <= S_REQ;
          end
`else
          if (cand_off && (WRAP == 0)) begin
            state_q <= S_BLOCK;
          end else begin
            wall_x_q   <= cand_x;
            wall_y_q   <= cand_y;
            wall_req_q <= 1'b1;
            state_q    <= S_REQ;
          end
`endif
        end
`ifdef TURN_BUFFER_EN
        // Fallback query straight ahead after a blocked turn.
        S_EVAL2: begin
          second_q      <= 1'b1;
          pending_dir_q <= req_dir_q;
          pending_vld_q <= 1'b1;
          if (cand_off && (WRAP == 0)) begin
            state_q <= S_BLOCK;
          end else begin
            wall_x_q   <= cand_x;
            wall_y_q   <= cand_y;
            wall_req_q <= 1'b1;
            state_q    <= S_REQ;
          end
        end
`endif
        S_REQ: begin
          if (wall_ack) begin
            wall_req_q <= 1'b0;
`ifdef TURN_BUFFER_EN
            if (!wall_blocked) begin
              if (!second_q) pending_vld_q <= 1'b0;
              state_q <= S_MOVE;
            end else if (!second_q && (req_dir_q != heading_q)) begin
              state_q <= S_EVAL2;
            end else begin
              state_q <= S_BLOCK;
            end
`else
            state_q <= wall_blocked ? S_BLOCK : S_MOVE;
`endif
          end
        end
        S_MOVE: begin
          pos_x_q     <= wall_x_q;
          pos_y_q     <= wall_y_q;
`ifdef TURN_BUFFER_EN
          if (!second_q) heading_q <= req_dir_q;
`else
          heading_q   <= req_dir_q;
`endif
          moving_q    <= 1'b1;
          move_tick_q <= 1'b1;
          if (step_count_q != 16'hFFFF) step_count_q <= step_count_q + 16'd1;
          state_q     <= S_RUN_WAIT;
        end
        S_BLOCK: begin
          moving_q <= 1'b0;
          state_q  <= S_RUN_WAIT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wall_req   = wall_req_q;
  assign wall_x     = wall_x_q;
  assign wall_y     = wall_y_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign heading    = heading_q;
  assign moving     = moving_q;
  assign move_tick  = move_tick_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl (default build): directed steps on three
// configurations plus a random walk on a tiny wrapping grid.
`timescale 1ns/1ps
module tb_sprite_motion_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic rst;

  // u0: default geometry, fast divider
  logic sg0, ack0, blk0;
  logic [1:0] dir0;
  logic req0, mv0, tk0;
  logic [7:0] wx0, wy0, px0, py0;
  logic [1:0] hd0;
  logic [15:0] sc0;

  // u1 (wrap) and u2 (clamp) start on the right edge, share inputs
  logic sge;
  logic [1:0] dire;
  logic req1, mv1, tk1, req2, mv2, tk2;
  logic [7:0] wx1, wy1, px1, py1, wx2, wy2, px2, py2;
  logic [1:0] hd1, hd2;
  logic [15:0] sc1, sc2;

  // u3: 4x3 wrapping grid for the random walk
  logic sg3, ack3, blk3;
  logic [1:0] dir3;
  logic req3, mv3, tk3;
  logic [7:0] wx3, wy3, px3, py3;
  logic [1:0] hd3;
  logic [15:0] sc3;

  sprite_motion_ctrl #(.STEP_DIV(4)) u0 (
    .CLOCK_50(clk), .reset(rst), .startGame(sg0), .direction(dir0),
    .wall_ack(ack0), .wall_blocked(blk0), .wall_req(req0),
    .wall_x(wx0), .wall_y(wy0), .pos_x(px0), .pos_y(py0),
    .heading(hd0), .moving(mv0), .move_tick(tk0), .step_count(sc0));

  sprite_motion_ctrl #(.STEP_DIV(4), .START_X(159), .WRAP(1)) u1 (
    .CLOCK_50(clk), .reset(rst), .startGame(sge), .direction(dire),
    .wall_ack(1'b1), .wall_blocked(1'b0), .wall_req(req1),
    .wall_x(wx1), .wall_y(wy1), .pos_x(px1), .pos_y(py1),
    .heading(hd1), .moving(mv1), .move_tick(tk1), .step_count(sc1));

  sprite_motion_ctrl #(.STEP_DIV(4), .START_X(159), .WRAP(0)) u2 (
    .CLOCK_50(clk), .reset(rst), .startGame(sge), .direction(dire),
    .wall_ack(1'b1), .wall_blocked(1'b0), .wall_req(req2),
    .wall_x(wx2), .wall_y(wy2), .pos_x(px2), .pos_y(py2),
    .heading(hd2), .moving(mv2), .move_tick(tk2), .step_count(sc2));

  sprite_motion_ctrl #(.GRID_W(4), .GRID_H(3), .START_X(1), .START_Y(1), .STEP_DIV(2)) u3 (
    .CLOCK_50(clk), .reset(rst), .startGame(sg3), .direction(dir3),
    .wall_ack(ack3), .wall_blocked(blk3), .wall_req(req3),
    .wall_x(wx3), .wall_y(wy3), .pos_x(px3), .pos_y(py3),
    .heading(hd3), .moving(mv3), .move_tick(tk3), .step_count(sc3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int n, hi;
  logic saw, stable;
  logic seen_req1, seen_tk1, req2_seen, tk2_seen;
  logic [7:0] wx1_cap, wy1_cap, px1_cap, hd1_cap, sc1_cap, mv1_cap;
  int mx, my, mh, mc, ex, ey, w;
  logic [1:0] d;
  logic b;

  initial begin
    rst = 1'b1;
    sg0 = 1'b0; dir0 = 2'd0; ack0 = 1'b0; blk0 = 1'b0;
    sge = 1'b0; dire = 2'd0;
    sg3 = 1'b0; dir3 = 2'd0; ack3 = 1'b0; blk3 = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;

    // Idle after reset with startGame low
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tk0 || req0) saw = 1'b1;
    end
    chk("idle_pos_x", px0, 80);
    chk("idle_pos_y", py0, 80);
    chk("idle_wall_req", req0, 0);
    chk("idle_step_count", sc0, 0);
    chk("idle_activity", saw, 0);
    chk("idle_wall_x", wx0, 0);
    chk("idle_heading", hd0, 0);
    chk("idle_moving", mv0, 0);

    // Run right with a free maze: 8 cycles to first tick, then every 7
    dir0 = 2'd1; ack0 = 1'b1; blk0 = 1'b0; sg0 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      do begin cyc(); n++; end while (!tk0 && n < 50);
      chk("tick_gap", n, (k == 1) ? 8 : 7);
      chk("step_pos_x", px0, 80 + k);
    end
    chk("run_step_count", sc0, 3);
    chk("run_heading", hd0, 1);
    chk("run_moving", mv0, 1);
    chk("run_pos_y", py0, 80);

    // Right edge: u1 wraps, u2 clamps
    sge = 1'b1; dire = 2'd1;
    seen_req1 = 1'b0; seen_tk1 = 1'b0; req2_seen = 1'b0; tk2_seen = 1'b0;
    wx1_cap = '0; wy1_cap = '0; px1_cap = '0; hd1_cap = '0; sc1_cap = '0; mv1_cap = '0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (req1 && !seen_req1) begin seen_req1 = 1'b1; wx1_cap = wx1; wy1_cap = wy1; end
      if (tk1 && !seen_tk1) begin
        seen_tk1 = 1'b1; px1_cap = px1; hd1_cap = {6'd0, hd1}; sc1_cap = sc1[7:0]; mv1_cap = {7'd0, mv1};
      end
      if (req2) req2_seen = 1'b1;
      if (tk2) tk2_seen = 1'b1;
    end
    chk("wrap_req_seen", seen_req1, 1);
    chk("wrap_wall_x", wx1_cap, 0);
    chk("wrap_wall_y", wy1_cap, 80);
    chk("wrap_tick_seen", seen_tk1, 1);
    chk("wrap_pos_x", px1_cap, 0);
    chk("wrap_heading", hd1_cap, 1);
    chk("wrap_step_count", sc1_cap, 1);
    chk("wrap_moving", mv1_cap, 1);
    chk("wrap_pos_y", py1, 80);
    chk("clamp_req_seen", req2_seen, 0);
    chk("clamp_tick_seen", tk2_seen, 0);
    chk("clamp_pos_x", px2, 159);
    chk("clamp_pos_y", py2, 80);
    chk("clamp_moving", mv2, 0);
    chk("clamp_step_count", sc2, 0);
    chk("clamp_heading", hd2, 0);
    chk("clamp_wall_x", wx2, 0);
    chk("clamp_wall_y", wy2, 0);
    sge = 1'b0;

    // Drop startGame for one cycle: back to start values
    sg0 = 1'b0;
    cyc();
    chk("restart_pos_x", px0, 80);
    chk("restart_step_count", sc0, 0);
    chk("restart_heading", hd0, 0);

    // Up into a wall, ack delayed 5 cycles
    ack0 = 1'b0; blk0 = 1'b1; dir0 = 2'd0; sg0 = 1'b1;
    n = 0;
    while (!req0 && n < 30) begin cyc(); n++; end
    chk("slow_req_seen", req0, 1);
    hi = 0; stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (req0) hi++;
      if (wy0 !== 8'd79 || wx0 !== 8'd80) stable = 1'b0;
      if (i < 5) cyc();
    end
    ack0 = 1'b1;
    cyc();
    ack0 = 1'b0;
    chk("slow_req_drop", req0, 0);
    chk("slow_req_high_cycles", hi, 6);
    chk("slow_cand_stable", stable, 1);
    cyc();
    chk("blocked_pos_x", px0, 80);
    chk("blocked_pos_y", py0, 80);
    chk("blocked_moving", mv0, 0);
    chk("blocked_heading", hd0, 0);

    // One clear step up, then abort mid-query
    blk0 = 1'b0; ack0 = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!tk0 && n < 30);
    chk("up_tick_seen", tk0, 1);
    chk("up_pos_y", py0, 79);
    chk("up_step_count", sc0, 1);
    ack0 = 1'b0;
    n = 0;
    while (!req0 && n < 30) begin cyc(); n++; end
    chk("abort_req_seen", req0, 1);
    cyc();
    chk("abort_req_cycle2", req0, 1);
    sg0 = 1'b0;
    cyc();
    ack0 = 1'b1;
    chk("abort_req_drop", req0, 0);
    chk("abort_pos_x", px0, 80);
    chk("abort_pos_y", py0, 80);
    chk("abort_step_count", sc0, 0);
    chk("abort_moving", mv0, 0);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tk0 || req0 || py0 !== 8'd80) saw = 1'b1;
    end
    chk("late_ack_ignored", saw, 0);
    ack0 = 1'b0;

    // Random walk on a 4x3 torus against a cell-level model
    mx = 1; my = 1; mh = 0; mc = 0;
    sg3 = 1'b1;
    for (int t = 0; t < 40; t++) begin
      d = 2'($urandom_range(0, 3));
      b = ($urandom_range(0, 2) == 0);
      w = $urandom_range(0, 3);
      dir3 = d;
      ex = mx; ey = my;
      case (d)
        2'd0: ey = (my + 2) % 3;
        2'd1: ex = (mx + 1) % 4;
        2'd2: ey = (my + 1) % 3;
        default: ex = (mx + 3) % 4;
      endcase
      n = 0;
      while (!req3 && n < 30) begin cyc(); n++; end
      chk("rnd_req_seen", req3, 1);
      chk("rnd_wall_x", wx3, ex);
      chk("rnd_wall_y", wy3, ey);
      repeat (w) cyc();
      chk("rnd_req_held", req3, 1);
      chk("rnd_wall_x_held", wx3, ex);
      chk("rnd_wall_y_held", wy3, ey);
      blk3 = b; ack3 = 1'b1;
      cyc();
      ack3 = 1'b0;
      chk("rnd_req_drop", req3, 0);
      cyc();
      if (!b) begin
        mx = ex; my = ey; mh = d; mc++;
      end
      chk("rnd_pos_x", px3, mx);
      chk("rnd_pos_y", py3, my);
      chk("rnd_heading", hd3, mh);
      chk("rnd_moving", mv3, !b);
      chk("rnd_tick", tk3, !b);
      chk("rnd_step_count", sc3, mc);
    end
    sg3 = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Parametrised player-motion controller for the Pacman game core; successor to the fixed start/direction stimulus path used at system level.
- Converts a held startGame level plus the 2-bit direction input into grid-stepped sprite motion at a programmable rate.
- Queries an external maze/wall lookup through a req/ack handshake before each step.
- Handles screen-edge wrap (tunnel) or clamp, and reports position, heading and step count to the renderer.

Parameters:
- X_W, 8, width of x coordinate
- Y_W, 8, width of y coordinate
- GRID_W, 160, number of columns (x legal range 0..GRID_W-1)
- GRID_H, 120, number of rows (y legal range 0..GRID_H-1)
- STEP_DIV, 500000, clock cycles spent in RUN_WAIT per step attempt (>=1)
- START_X, 80, x position after reset or return to IDLE
- START_Y, 80, y position after reset or return to IDLE
- WRAP, 1, 1 = edge wrap-around (tunnel), 0 = edge treated as wall

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- startGame  in  1  level; 1 = play, 0 = return to IDLE
- direction  in  2  requested heading: 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1)
- wall_ack  in  1  lookup response valid; may assert in the same cycle as wall_req
- wall_blocked  in  1  qualified by wall_ack; 1 = target cell is a wall
- wall_req  out  1  lookup request; held until wall_ack
- wall_x  out  X_W  candidate x; stable while wall_req=1
- wall_y  out  Y_W  candidate y; stable while wall_req=1
- pos_x  out  X_W  current sprite x
- pos_y  out  Y_W  current sprite y
- heading  out  2  direction of the last successful step
- moving  out  1  1 if the last step attempt succeeded
- move_tick  out  1  one-cycle pulse on each position update
- step_count  out  16  successful steps since IDLE; saturates at 16'hFFFF

Behaviour:
- Reset (synchronous, active-high), all outputs: pos=START_X/START_Y, heading=0, moving=0, move_tick=0, step_count=0, wall_req=0, wall_x/wall_y=0, state=IDLE.
- IDLE: outputs held at reset values. When startGame=1 -> RUN_WAIT with the divider at 0.
- RUN_WAIT: divider counts 0..STEP_DIV-1, then -> EVAL. The divider runs only in this state and clears on exit.
- EVAL (1 cycle):
  - Sample direction into req_dir.
  - Candidate = pos +/- 1 on the req_dir axis.
  - Off-grid candidate with WRAP=1: wraps; x: GRID_W-1 -> 0 and 0 -> GRID_W-1; same rule for y with GRID_H.
  - Off-grid candidate with WRAP=0: treated as blocked with no wall_req issued -> BLOCK.
  - Otherwise load wall_x/wall_y -> REQ.
- REQ: wall_req=1 until wall_ack is sampled high.
  - wall_blocked=0 -> MOVE.
  - wall_blocked=1 -> BLOCK.
  - wall_req drops the cycle after ack.
- MOVE (1 cycle): pos <= candidate, heading <= req_dir, moving <= 1, move_tick=1, step_count++ (saturating) -> RUN_WAIT.
- BLOCK (1 cycle): pos unchanged, moving <= 0, heading unchanged -> RUN_WAIT.
- Step period with zero-wait ack: STEP_DIV + 3 cycles (RUN_WAIT + EVAL + REQ + MOVE).
- startGame=0 in any non-IDLE state: next cycle -> IDLE with full output re-initialisation (same values as reset). An in-flight wall_req drops immediately; a late wall_ack is ignored.
- wall_ack outside REQ: ignored.
- Reset has priority over startGame.

Optional Feature:
- Macro: TURN_BUFFER_EN.
- Defined:
  - When a query for req_dir != heading returns blocked, issue a second query using the current heading (EVAL2 -> REQ).
  - If that query is clear, MOVE along heading; heading is not changed.
  - req_dir is retained as pending_dir and retried at each following tick until it succeeds or direction changes.
  - Gives corner pre-turn feel.
- Not defined: a blocked query goes straight to BLOCK; no second query and no pending_dir register.

Test Plan:
- Reset, STEP_DIV=4, startGame=0 for 10 cycles -> pos=(80,80), wall_req=0, step_count=0, move_tick never high.
- startGame=1, direction=1, ack tied high with blocked=0 -> move_tick every 7 cycles; pos_x 81, 82, 83; step_count=3; heading=1; moving=1.
- START_X=159, direction=1, WRAP=1 -> wall_x=0, pos_x=0. Same with WRAP=0 -> wall_req never asserts, pos_x stays 159, moving=0.
- direction=0, wall_blocked=1, ack delayed 5 cycles -> wall_req high 6 cycles with wall_y=79 stable; pos stays (80,80); moving=0.
- startGame dropped in REQ cycle 2, ack arrives 1 cycle later -> next cycle wall_req=0, pos=(80,80), step_count=0; late ack causes no move.
- TURN_BUFFER_EN: heading=1, direction=0 blocked, right clear -> two requests per tick (wall_y=79, then wall_x=81); pos_x=81, heading stays 1. Unblock up -> next tick pos_y=79, heading=0.
